sort_unload: RTL and testbench

Downstream drain stage for the 32-entry bubble sorter. Captures the sorter's sorted array in one cycle when the sorter reports completion, pulses `ack` back to release the sorter, then streams the elements out one per cycle, lowest index first, over a valid/ready interface. Decoupling the output stream this way lets the sorter return to its initial state and accept a new job while the previous result is still draining.

---
 rtl/sort_unload_if.sv | 26 ++
 rtl/sort_unload.sv | 123 ++++++++++++
 tb/tb_sort_unload.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sort_unload_if.sv
// Handshake bundle between the bubble sorter, the sort_unload drain stage and the consumer.
// The slave modport is the drain stage's view; the master modport is the sorter/consumer side.
interface sort_unload_if #(
    parameter int N = 32,
    parameter int W = 8
);
    logic             sort_done;
    logic [N*W-1:0]   sorted_flat;
    logic             ack;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic             out_last;
    logic             busy;
    logic             order_err;

    modport master (
        output sort_done, sorted_flat, out_ready,
        input  ack, out_valid, out_data, out_last, busy, order_err
    );

    modport slave (
        input  sort_done, sorted_flat, out_ready,
        output ack, out_valid, out_data, out_last, busy, order_err
    );
endinterface

// File: rtl/sort_unload.sv
// Drain stage: snapshots the sorter's array, acks it, then streams elements out over valid/ready.
// Optional ordering checker enabled by defining SORT_UNLOAD_CHECK_EN.
module sort_unload #(
    parameter int N = 32,
    parameter int W = 8
) (
    input logic          clk,
    input logic          reset,
    sort_unload_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t          state_q;
    logic [IW-1:0]   rd_idx_q;
    logic [IW-1:0]   rd_idx_d;
    logic            armed_q;
    logic            ack_q;
    logic            valid_q;
    logic            last_q;
    logic            busy_q;
    logic [W-1:0]    data_q;
    logic [W-1:0]    buf_q [N];

    logic capture;
    logic xfer;
    logic is_last;

    always_comb begin
        capture  = (state_q == IDLE) && bus.sort_done && armed_q;
        xfer     = valid_q && bus.out_ready;
        is_last  = (rd_idx_q == IW'(N - 1));
        rd_idx_d = rd_idx_q + IW'(1);
    end

    // Buffer is written only at capture, so it stays frozen for the whole drain.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= bus.sorted_flat[W*i +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rd_idx_q <= '0;
            armed_q  <= 1'b0;
            ack_q    <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            data_q   <= '0;
        end else begin
            ack_q <= 1'b0;
            // armed only re-arms after sort_done has been seen low, so a held result is taken once.
            if (!bus.sort_done) begin
                armed_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (capture) begin
                        state_q  <= DRAIN;
                        ack_q    <= 1'b1;
                        rd_idx_q <= '0;
                        armed_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        valid_q  <= 1'b1;
                        data_q   <= bus.sorted_flat[W-1:0];
                        last_q   <= (N == 1);
                    end
                end
                DRAIN: begin
                    if (xfer) begin
                        if (is_last) begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            last_q  <= 1'b0;
                        end else begin
                            rd_idx_q <= rd_idx_d;
                            data_q   <= buf_q[rd_idx_d];
                            last_q   <= (rd_idx_d == IW'(N - 1));
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ack       = ack_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_last  = last_q;
    assign bus.busy      = busy_q;

`ifdef SORT_UNLOAD_CHECK_EN
    logic [W-1:0] prev_q;
    logic         order_err_q;

    always_ff @(posedge clk) begin
        if (xfer) begin
            prev_q <= data_q;
        end
    end

    // Element 0 of each job has no predecessor; prev_q is only meaningful from element 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            order_err_q <= 1'b0;
        end else if (xfer && (rd_idx_q != '0) && (data_q < prev_q)) begin
            order_err_q <= 1'b1;
        end
    end

    assign bus.order_err = order_err_q;
`else
    assign bus.order_err = 1'b0;
`endif
endmodule

// File: tb/tb_sort_unload.sv
// Self-checking bench for sort_unload: randomized sorted jobs checked against an index-order model.
module tb_sort_unload;
    localparam int N = 32;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sort_unload_if #(.N(N), .W(W)) bus_if ();
    sort_unload #(.N(N), .W(W)) dut (.clk(clk), .reset(reset), .bus(bus_if));

    int tests = 0;
    int fails = 0;

    logic [W-1:0] arr [N];
    logic [W-1:0] got_q [$];
    int           got_cyc [$];
    bit           got_last [$];
    bit           got_oe [$];
    int           ack_cyc [$];
    int           stall_err;

`ifdef SORT_UNLOAD_CHECK_EN
    localparam bit CHECK_ON = 1'b1;
`else
    localparam bit CHECK_ON = 1'b0;
`endif

    task automatic load_arr();
        for (int i = 0; i < N; i++) bus_if.sorted_flat[W*i +: W] = arr[i];
    endtask

    task automatic fill_sorted();
        logic [W-1:0] q [$];
        for (int i = 0; i < N; i++) q.push_back(W'($urandom));
        q.sort();
        for (int i = 0; i < N; i++) arr[i] = q[i];
        load_arr();
    endtask

    // Consumer/monitor: mode 0 ready=1, mode 1 ready pattern 1,0,0,1, mode 2 random ready.
    task automatic run_drain(input int mode, input int stop_after, input int max_cyc, input bit drop_on_ack);
        logic [W-1:0] pd;
        bit pstall;
        bit r;
        pd = '0;
        pstall = 1'b0;
        got_q.delete(); got_cyc.delete(); got_last.delete(); got_oe.delete(); ack_cyc.delete();
        stall_err = 0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (bus_if.ack === 1'b1) begin
                ack_cyc.push_back(c);
                if (drop_on_ack) bus_if.sort_done = 1'b0;
            end
            if (pstall && (bus_if.out_data !== pd || bus_if.out_valid !== 1'b1)) stall_err++;
            case (mode)
                0: r = 1'b1;
                1: r = ((c % 4) == 0) || ((c % 4) == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            bus_if.out_ready = r;
            if (bus_if.out_valid === 1'b1 && r) begin
                got_q.push_back(bus_if.out_data);
                got_cyc.push_back(c);
                got_last.push_back(bus_if.out_last);
                got_oe.push_back(bus_if.order_err);
            end
            pstall = (bus_if.out_valid === 1'b1) && !r;
            pd = bus_if.out_data;
            if (got_q.size() == stop_after) break;
        end
    endtask

    function automatic int first_bad();
        for (int i = 0; i < N; i++) begin
            if (i >= got_q.size()) return i;
            if (got_q[i] !== arr[i]) return i;
        end
        return -1;
    endfunction

    task automatic start_job();
        @(negedge clk);
        bus_if.sort_done = 1'b0;
        @(negedge clk);
        bus_if.sort_done = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_if.sort_done = 1'b0;
        bus_if.out_ready = 1'b0;
        bus_if.sorted_flat = '0;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (bus_if.ack !== 1'b0) begin fails++; $display("FAIL reset_ack got %b want 0", bus_if.ack); end
        tests++; if (bus_if.out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", bus_if.out_valid); end
        tests++; if (bus_if.out_data !== '0) begin fails++; $display("FAIL reset_data got %h want 00", bus_if.out_data); end
        tests++; if (bus_if.out_last !== 1'b0) begin fails++; $display("FAIL reset_last got %b want 0", bus_if.out_last); end
        tests++; if (bus_if.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus_if.busy); end
        tests++; if (bus_if.order_err !== 1'b0) begin fails++; $display("FAIL reset_order_err got %b want 0", bus_if.order_err); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        int bad;
        int nlast;
        for (int i = 0; i < N; i++) arr[i] = W'(2 * i);
        load_arr();
        start_job();
        run_drain(0, N, 200, 1'b1);
        @(posedge clk); #1;
        tests++; if (ack_cyc.size() != 1) begin fails++; $display("FAIL basic_ack_count got %0d want 1", ack_cyc.size()); end
        tests++; if (got_q.size() != N) begin fails++; $display("FAIL basic_xfer_count got %0d want %0d", got_q.size(), N); end
        bad = first_bad();
        tests++; if (bad != -1) begin fails++; $display("FAIL basic_data first bad index %0d want value %h", bad, arr[bad]); end
        tests++;
        if (got_cyc.size() != N || got_cyc[N-1] - got_cyc[0] != N - 1) begin
            fails++; $display("FAIL basic_consecutive got %0d transfers, span wrong, want span %0d", got_cyc.size(), N - 1);
        end
        nlast = 0;
        for (int i = 0; i < got_last.size(); i++) if (got_last[i] != (i == N - 1)) nlast++;
        tests++; if (nlast != 0) begin fails++; $display("FAIL basic_last got %0d misplaced out_last want 0", nlast); end
        tests++;
        if (ack_cyc.size() == 0 || got_cyc.size() == 0 || ack_cyc[0] != got_cyc[0]) begin
            fails++; $display("FAIL basic_ack_timing ack not in first valid cycle");
        end
        tests++; if (bus_if.busy !== 1'b0 || bus_if.out_valid !== 1'b0) begin
            fails++; $display("FAIL basic_idle_after busy=%b valid=%b want 0 0", bus_if.busy, bus_if.out_valid);
        end
    endtask

    task automatic test_hold();
        int bad;
        fill_sorted();
        start_job();
        run_drain(2, N, 400, 1'b0);
        @(posedge clk);
        tests++; if (ack_cyc.size() != 1 || got_q.size() != N) begin
            fails++; $display("FAIL hold_first acks %0d xfers %0d want 1 %0d", ack_cyc.size(), got_q.size(), N);
        end
        bad = first_bad();
        tests++; if (bad != -1 || stall_err != 0) begin fails++; $display("FAIL hold_data bad %0d stalls %0d want -1 0", bad, stall_err); end
        run_drain(0, 1000, 60, 1'b0);
        tests++; if (ack_cyc.size() != 0 || got_q.size() != 0) begin
            fails++; $display("FAIL hold_no_recapture acks %0d xfers %0d want 0 0", ack_cyc.size(), got_q.size());
        end
        fill_sorted();
        start_job();
        run_drain(0, N, 200, 1'b1);
        @(posedge clk);
        bad = first_bad();
        tests++; if (ack_cyc.size() != 1 || bad != -1) begin
            fails++; $display("FAIL hold_second acks %0d bad %0d want 1 -1", ack_cyc.size(), bad);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        fill_sorted();
        start_job();
        run_drain(1, N, 400, 1'b1);
        @(posedge clk);
        tests++; if (got_q.size() != N) begin fails++; $display("FAIL bp_count got %0d want %0d", got_q.size(), N); end
        bad = first_bad();
        tests++; if (bad != -1) begin fails++; $display("FAIL bp_data first bad index %0d", bad); end
        tests++; if (stall_err != 0) begin fails++; $display("FAIL bp_hold got %0d unstable stalls want 0", stall_err); end
    endtask

    task automatic test_reset_mid();
        int bad;
        fill_sorted();
        start_job();
        run_drain(0, 10, 200, 1'b1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        tests++; if (bus_if.out_valid !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.ack !== 1'b0) begin
            fails++; $display("FAIL midreset_outputs valid=%b busy=%b ack=%b want 0 0 0", bus_if.out_valid, bus_if.busy, bus_if.ack);
        end
        @(negedge clk);
        fill_sorted();
        bus_if.sort_done = 1'b1;
        reset = 1'b1;
        run_drain(0, 1000, 20, 1'b0);
        tests++; if (ack_cyc.size() != 0 || got_q.size() != 0) begin
            fails++; $display("FAIL midreset_unarmed acks %0d xfers %0d want 0 0", ack_cyc.size(), got_q.size());
        end
        start_job();
        run_drain(0, N, 200, 1'b1);
        @(posedge clk);
        bad = first_bad();
        tests++; if (got_q.size() != N || bad != -1) begin
            fails++; $display("FAIL midreset_restart xfers %0d bad %0d want %0d -1", got_q.size(), bad, N);
        end
    endtask

    task automatic test_order();
        int bad;
        for (int i = 0; i < N; i++) arr[i] = (i < 5) ? W'(i) : W'(8'h20 + i);
        arr[5] = 8'h10;
        arr[6] = 8'h0F;
        load_arr();
        start_job();
        run_drain(0, N, 200, 1'b1);
        @(posedge clk); #1;
        bad = 0;
        for (int k = 0; k < got_oe.size(); k++) if (got_oe[k] != (CHECK_ON && k >= 7)) bad++;
        tests++; if (got_q.size() != N || bad != 0) begin
            fails++; $display("FAIL order_flag xfers %0d wrong samples %0d want %0d 0", got_q.size(), bad, N);
        end
        tests++; if (bus_if.order_err !== CHECK_ON) begin
            fails++; $display("FAIL order_sticky got %b want %b", bus_if.order_err, CHECK_ON);
        end
        fill_sorted();
        start_job();
        run_drain(2, N, 400, 1'b1);
        @(posedge clk); #1;
        bad = 0;
        for (int k = 0; k < got_oe.size(); k++) if (got_oe[k] != CHECK_ON) bad++;
        tests++; if (got_q.size() != N || bad != 0 || bus_if.order_err !== CHECK_ON) begin
            fails++; $display("FAIL order_second xfers %0d wrong samples %0d err %b want %0d 0 %b",
                              got_q.size(), bad, bus_if.order_err, N, CHECK_ON);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_backpressure();
        test_reset_mid();
        test_order();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
